// File: rtl/rggen_host_if_sequencer.sv
// rggen_host_if_sequencer
//   Host-side command sequencer for a register block. A single host request is
//   accepted, broadcast to every register slot as a command, and the combined
//   select/ready/read-data returned by the slots becomes one response.
//   Optional feature macro: RGGEN_HOST_IF_TIMEOUT_EN adds a COMMAND-phase
//   timeout that ends a stalled access with a slave-error status.
module rggen_host_if_sequencer #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 4,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_request_valid,
  output logic                                  o_request_ready,
  input  logic                                  i_request_write,
  input  logic [ADDRESS_WIDTH-1:0]              i_request_address,
  input  logic [DATA_WIDTH-1:0]                 i_request_write_data,
  input  logic [DATA_WIDTH/8-1:0]               i_request_strobe,
  output logic                                  o_command_valid,
  output logic                                  o_command_write,
  output logic [ADDRESS_WIDTH-1:0]              o_command_address,
  output logic [DATA_WIDTH-1:0]                 o_command_write_data,
  output logic [DATA_WIDTH-1:0]                 o_command_write_mask,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data
);

  localparam logic [1:0] STATUS_OK           = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMAND  = 2'd1,
    ST_RESPONSE = 2'd2
  } state_e;

  // Expand byte enables into a bit-level write mask (8 bits per strobe bit).
  function automatic logic [DATA_WIDTH-1:0] expand_strobe(
    input logic [DATA_WIDTH/8-1:0] strobe
  );
    logic [DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      mask[b*8+:8] = {8{strobe[b]}};
    end
    return mask;
  endfunction

  state_e                   r_state;
  state_e                   w_next_state;

  logic                     r_command_write;
  logic [ADDRESS_WIDTH-1:0] r_command_address;
  logic [DATA_WIDTH-1:0]    r_command_write_data;
  logic [DATA_WIDTH-1:0]    r_command_write_mask;

  logic [1:0]               r_response_status;
  logic [DATA_WIDTH-1:0]    r_response_read_data;

  logic                     w_accept;
  logic                     w_finish;
  logic                     w_response_done;
  logic [1:0]               w_status_next;
  logic [DATA_WIDTH-1:0]    w_read_data_next;

  logic [TOTAL_REGISTERS-1:0] w_select_ready;
  logic                       w_hit;
  logic                       w_done;
  logic [DATA_WIDTH-1:0]      w_read_data;

  assign w_select_ready = i_register_select & i_register_ready;
  assign w_hit          = |i_register_select;
  assign w_done         = |w_select_ready;

  // OR-combine the read data of every slot that is both selected and ready.
  always_comb begin
    w_read_data = '0;
    for (int k = 0; k < TOTAL_REGISTERS; k++) begin
      w_read_data = w_read_data |
        (i_register_read_data[k*DATA_WIDTH+:DATA_WIDTH] & {DATA_WIDTH{w_select_ready[k]}});
    end
  end

`ifdef RGGEN_HOST_IF_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_count_inc;
  logic                   w_timeout;

  // The limit is hit on the TIMEOUT_CYCLES-th stalled command cycle, since the
  // counter still reads 0 during the first one.
  assign w_timeout = (r_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Stall counter: advances on each stalled command cycle, cleared when the response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_response_done) begin
      r_count <= '0;
    end else if (w_count_inc) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end
`endif

  // Next-state and transition decode for the IDLE -> COMMAND -> RESPONSE loop.
  always_comb begin
    w_next_state     = r_state;
    w_accept         = 1'b0;
    w_finish         = 1'b0;
    w_response_done  = 1'b0;
    w_status_next    = STATUS_OK;
    w_read_data_next = '0;
`ifdef RGGEN_HOST_IF_TIMEOUT_EN
    w_count_inc      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_request_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_COMMAND;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_COMMAND: begin
        if (!w_hit) begin
          w_finish      = 1'b1;
          w_status_next = STATUS_DECODE_ERROR;
          w_next_state  = ST_RESPONSE;
        end else if (w_done) begin
          // A done on the same cycle the limit is reached still completes OK.
          w_finish      = 1'b1;
          w_status_next = STATUS_OK;
          if (r_command_write) begin
            w_read_data_next = '0;
          end else begin
            w_read_data_next = w_read_data;
          end
          w_next_state  = ST_RESPONSE;
        end else begin
`ifdef RGGEN_HOST_IF_TIMEOUT_EN
          if (w_timeout) begin
            w_finish      = 1'b1;
            w_status_next = STATUS_SLAVE_ERROR;
            w_next_state  = ST_RESPONSE;
          end else begin
            w_count_inc   = 1'b1;
            w_next_state  = ST_COMMAND;
          end
`else
          w_next_state = ST_COMMAND;
`endif
        end
      end
      ST_RESPONSE: begin
        if (i_response_ready) begin
          w_response_done = 1'b1;
          w_next_state    = ST_IDLE;
        end else begin
          w_next_state    = ST_RESPONSE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the request fields on acceptance; they stay frozen through COMMAND.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_command_write      <= 1'b0;
      r_command_address    <= '0;
      r_command_write_data <= '0;
      r_command_write_mask <= '0;
    end else if (w_accept) begin
      r_command_write      <= i_request_write;
      r_command_address    <= i_request_address;
      r_command_write_data <= i_request_write_data;
      if (i_request_write) begin
        r_command_write_mask <= expand_strobe(i_request_strobe);
      end else begin
        r_command_write_mask <= '0;
      end
    end else begin
      r_command_write      <= r_command_write;
      r_command_address    <= r_command_address;
      r_command_write_data <= r_command_write_data;
      r_command_write_mask <= r_command_write_mask;
    end
  end

  // Response status/data: loaded when COMMAND ends, held until the host takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_response_status    <= 2'b00;
      r_response_read_data <= '0;
    end else if (w_finish) begin
      r_response_status    <= w_status_next;
      r_response_read_data <= w_read_data_next;
    end else if (w_response_done) begin
      r_response_status    <= 2'b00;
      r_response_read_data <= '0;
    end else begin
      r_response_status    <= r_response_status;
      r_response_read_data <= r_response_read_data;
    end
  end

  // Handshake outputs are decoded from state and forced low while rst is held,
  // so an abandoned transaction never shows a command or response again.
  assign o_request_ready      = (r_state == ST_IDLE)     && !rst;
  assign o_command_valid      = (r_state == ST_COMMAND)  && !rst;
  assign o_response_valid     = (r_state == ST_RESPONSE) && !rst;
  assign o_command_write      = r_command_write;
  assign o_command_address    = r_command_address;
  assign o_command_write_data = r_command_write_data;
  assign o_command_write_mask = r_command_write_mask;
  assign o_response_status    = rst ? 2'b00 : r_response_status;
  assign o_response_read_data = rst ? '0    : r_response_read_data;

endmodule

// File: tb/tb_rggen_host_if_sequencer.sv
// Self-checking bench for rggen_host_if_sequencer: directed vector table,
// randomized transactions against a transaction-level model, back-pressure
// and reset-in-flight sequences. Build with RGGEN_HOST_IF_TIMEOUT_EN to
// exercise the timeout path (TIMEOUT_CYCLES = 4 here).
module tb_rggen_host_if_sequencer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_request_valid = 1'b0;
  logic            o_request_ready;
  logic            i_request_write = 1'b0;
  logic [AW-1:0]   i_request_address = '0;
  logic [DW-1:0]   i_request_write_data = '0;
  logic [DW/8-1:0] i_request_strobe = '0;
  logic            o_command_valid;
  logic            o_command_write;
  logic [AW-1:0]   o_command_address;
  logic [DW-1:0]   o_command_write_data;
  logic [DW-1:0]   o_command_write_mask;
  logic [NR-1:0]   i_register_select = '0;
  logic [NR-1:0]   i_register_ready = '0;
  logic [NR*DW-1:0] i_register_read_data = '0;
  logic            o_response_valid;
  logic            i_response_ready = 1'b0;
  logic [1:0]      o_response_status;
  logic [DW-1:0]   o_response_read_data;

  rggen_host_if_sequencer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_request_valid(i_request_valid), .o_request_ready(o_request_ready),
    .i_request_write(i_request_write), .i_request_address(i_request_address),
    .i_request_write_data(i_request_write_data), .i_request_strobe(i_request_strobe),
    .o_command_valid(o_command_valid), .o_command_write(o_command_write),
    .o_command_address(o_command_address), .o_command_write_data(o_command_write_data),
    .o_command_write_mask(o_command_write_mask),
    .i_register_select(i_register_select), .i_register_ready(i_register_ready),
    .i_register_read_data(i_register_read_data),
    .o_response_valid(o_response_valid), .i_response_ready(i_response_ready),
    .o_response_status(o_response_status), .o_response_read_data(o_response_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          slot;        // -1: nobody selects
    int          ready_cyc;   // command cycle on which the slot goes ready, 0 = never
    logic [31:0] rdata;
    int          resp_delay;  // cycles the host holds off i_response_ready
    int          exp_cycles;
    logic [31:0] exp_mask;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;

`ifdef RGGEN_HOST_IF_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level reference: what the host should observe for one access.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_mask = 32'h0;
    if (v.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (v.strb[b]) r.exp_mask = r.exp_mask | (32'hFF << (8 * b));
      end
    end
    if (v.slot < 0) begin
      r.exp_cycles = 1; r.exp_status = 2'b11; r.exp_rdata = 32'h0;
    end else if (v.ready_cyc != 0 && (!TIMEOUT_ON || v.ready_cyc <= TO)) begin
      r.exp_cycles = v.ready_cyc; r.exp_status = 2'b00;
      r.exp_rdata  = v.wr ? 32'h0 : v.rdata;
    end else begin
      r.exp_cycles = TO; r.exp_status = 2'b10; r.exp_rdata = 32'h0;
    end
    return r;
  endfunction

  // Request that is left pending during the response phase of the current one.
  logic        nxt_wr;
  logic [15:0] nxt_addr;
  logic [31:0] nxt_wdata;
  logic [3:0]  nxt_strb;

  task automatic run_txn(input vec_t v, input bit pend);
    int cnt;
    int guard;
    i_request_valid      = 1'b1;
    i_request_write      = v.wr;
    i_request_address    = v.addr;
    i_request_write_data = v.wdata;
    i_request_strobe     = v.strb;
    guard = 0;
    while (!o_request_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("request_ready_wait", 64'd0, 64'd1);
    @(negedge clk);
    // scramble request inputs: they must be ignored outside IDLE
    i_request_valid      = 1'($urandom);
    i_request_write      = 1'($urandom);
    i_request_address    = 16'($urandom);
    i_request_write_data = $urandom;
    i_request_strobe     = 4'($urandom);
    cnt = 0;
    while (o_command_valid && cnt < 100) begin
      cnt++;
      chk("cmd_write", 64'(o_command_write), 64'(v.wr));
      chk("cmd_addr", 64'(o_command_address), 64'(v.addr));
      chk("cmd_wdata", 64'(o_command_write_data), 64'(v.wdata));
      chk("cmd_mask", 64'(o_command_write_mask), 64'(v.exp_mask));
      chk("req_ready_in_cmd", 64'(o_request_ready), 64'd0);
      i_register_select    = '0;
      i_register_ready     = 4'($urandom);
      i_register_read_data = {$urandom, $urandom, $urandom, $urandom};
      i_response_ready     = 1'($urandom);
      if (v.slot >= 0) begin
        i_register_select[v.slot] = 1'b1;
        i_register_ready[v.slot]  = (v.ready_cyc != 0 && cnt >= v.ready_cyc);
        i_register_read_data[v.slot*DW+:DW] = v.rdata;
      end
      @(negedge clk);
    end
    i_register_select = '0;
    i_register_ready  = '0;
    i_response_ready  = 1'b0;
    i_request_valid   = 1'b0;
    chk("cmd_cycles", 64'(cnt), 64'(v.exp_cycles));
    chk("resp_valid", 64'(o_response_valid), 64'd1);
    chk("resp_status", 64'(o_response_status), 64'(v.exp_status));
    chk("resp_rdata", 64'(o_response_read_data), 64'(v.exp_rdata));
    if (pend) begin
      i_request_valid      = 1'b1;
      i_request_write      = nxt_wr;
      i_request_address    = nxt_addr;
      i_request_write_data = nxt_wdata;
      i_request_strobe     = nxt_strb;
    end
    for (int d = 0; d < v.resp_delay; d++) begin
      @(negedge clk);
      chk("resp_hold_valid", 64'(o_response_valid), 64'd1);
      chk("resp_hold_status", 64'(o_response_status), 64'(v.exp_status));
      chk("resp_hold_rdata", 64'(o_response_read_data), 64'(v.exp_rdata));
      chk("req_ready_in_resp", 64'(o_request_ready), 64'd0);
      chk("no_cmd_in_resp", 64'(o_command_valid), 64'd0);
    end
    i_response_ready = 1'b1;
    @(negedge clk);
    i_response_ready = 1'b0;
    chk("resp_dropped", 64'(o_response_valid), 64'd0);
    chk("req_ready_after", 64'(o_request_ready), 64'd1);
  endtask

  vec_t table_v[4];
  vec_t v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // directed vectors with hand-derived expectations
    table_v[0] = '{1'b1, 16'h0004, 32'hA5A5_1234, 4'b0011, 1, 1, 32'h1111_1111, 0,
                   1, 32'h0000_FFFF, 2'b00, 32'h0};
    table_v[1] = '{1'b0, 16'h0008, 32'h0, 4'b0000, 2, 3, 32'hDEAD_BEEF, 1,
                   3, 32'h0, 2'b00, 32'hDEAD_BEEF};
    table_v[2] = '{1'b0, 16'h00F0, 32'h0, 4'b1111, -1, 0, 32'h0, 2,
                   1, 32'h0, 2'b11, 32'h0};
`ifdef RGGEN_HOST_IF_TIMEOUT_EN
    table_v[3] = '{1'b0, 16'h0010, 32'h0, 4'b0000, 0, 0, 32'h1234_5678, 0,
                   4, 32'h0, 2'b10, 32'h0};
`else
    table_v[3] = '{1'b0, 16'h0010, 32'h0, 4'b0000, 0, 20, 32'hCAFE_F00D, 0,
                   20, 32'h0, 2'b00, 32'hCAFE_F00D};
`endif

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(o_request_ready), 64'd0);
    chk("rst_cmd_valid", 64'(o_command_valid), 64'd0);
    chk("rst_resp_valid", 64'(o_response_valid), 64'd0);
    chk("rst_status", 64'(o_response_status), 64'd0);
    chk("rst_rdata", 64'(o_response_read_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 64'(o_request_ready), 64'd1);

    for (int i = 0; i < 4; i++) run_txn(table_v[i], 1'b0);

    // back-pressure: response held 5 cycles with the next request pending
    nxt_wr = 1'b1; nxt_addr = 16'h0040; nxt_wdata = 32'h0BAD_F00D; nxt_strb = 4'b1100;
    v = '{1'b0, 16'h0020, 32'h0, 4'b0, 3, 2, 32'h5555_AAAA, 5, 0, 32'h0, 2'b00, 32'h0};
    run_txn(model(v), 1'b1);
    v = '{nxt_wr, nxt_addr, nxt_wdata, nxt_strb, 0, 1, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0};
    run_txn(model(v), 1'b0);

    // reset during the 2nd cycle of a stalled command
    i_request_valid = 1'b1; i_request_write = 1'b0; i_request_address = 16'h0030;
    @(negedge clk);
    i_request_valid = 1'b0;
    chk("mid_cmd_c1", 64'(o_command_valid), 64'd1);
    i_register_select = 4'b0001;
    @(negedge clk);
    chk("mid_cmd_c2", 64'(o_command_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_valid", 64'(o_command_valid), 64'd0);
    chk("mid_rst_resp_valid", 64'(o_response_valid), 64'd0);
    chk("mid_rst_req_ready", 64'(o_request_ready), 64'd0);
    rst = 1'b0;
    i_register_select = '0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(o_request_ready), 64'd1);
    chk("post_rst_cmd_valid", 64'(o_command_valid), 64'd0);
    chk("post_rst_resp_valid", 64'(o_response_valid), 64'd0);
    v = '{1'b1, 16'h0034, 32'h7777_8888, 4'b1111, 1, 2, 32'h0, 0, 0, 32'h0, 2'b00, 32'h0};
    run_txn(model(v), 1'b0);

    // randomized transactions against the model
    for (int i = 0; i < 30; i++) begin
      v.wr         = 1'($urandom);
      v.addr       = 16'($urandom);
      v.wdata      = $urandom;
      v.strb       = 4'($urandom);
      v.slot       = int'($urandom_range(0, 4)) - 1;
      v.ready_cyc  = TIMEOUT_ON ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      v.rdata      = $urandom;
      v.resp_delay = int'($urandom_range(0, 3));
      run_txn(model(v), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
